// File: rtl/fetch_pc_unit.sv
// Program counter and next-PC selection for the single-cycle CPU, including
// trap entry, eret return, EPC/cause tracking and edge-captured interrupts.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter logic [31:0] HANDLER_VECTOR = 32'h0000_0070,
    parameter logic [4:0]  INT_CODE       = 5'd0,
    parameter logic [4:0]  ADEL_CODE      = 5'd4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [15:0] Imm16,
    input  logic        JumpEn,
    input  logic [25:0] JumpIdx,
    input  logic        JrEn,
    input  logic [31:0] RegTarget,
    input  logic        Eret,
    input  logic        ExcReq,
    input  logic [4:0]  ExcCode,
    input  logic        IntReq,
    input  logic        IE,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] EPC,
    output logic [4:0]  CauseCode,
    output logic        InHandler
);

    logic [31:0] pc_q;
    logic [31:0] epc_q;
    logic [4:0]  cause_q;
    logic        in_handler_q;
    logic        int_pending;
    logic        int_prev;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] seq_next;
    logic        adel;
    logic        exc_take;
    logic        int_take;
    logic        int_edge;
    logic        int_clear;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {{14{Imm16[15]}}, Imm16, 2'b00};
    assign jump_target   = {pc_plus4[31:28], JumpIdx, 2'b00};

    assign adel      = JrEn & (RegTarget[1:0] != 2'b00);
    assign exc_take  = ExcReq | adel;
    assign int_take  = int_pending & IE & ~in_handler_q;
    assign int_edge  = IntReq & ~int_prev;
    // A synchronous fault outranks the interrupt, so the pending bit survives it.
    assign int_clear = ~Stall & ~exc_take & int_take;

    always_comb begin
        // NOTE: default first so every path assigns seq_next and no latch is inferred.
        seq_next = pc_plus4;
        if (JrEn)
            seq_next = RegTarget;
        else if (JumpEn)
            seq_next = jump_target;
        else if (BranchTaken)
            seq_next = branch_target;
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q         <= RESET_VECTOR;
            epc_q        <= 32'd0;
            cause_q      <= 5'd0;
            in_handler_q <= 1'b0;
            int_pending  <= 1'b0;
            int_prev     <= 1'b0;
        end else begin
            // Edge capture runs even while stalled so no request is lost.
            int_prev    <= IntReq;
            int_pending <= (int_pending & ~int_clear) | int_edge;

            if (!Stall) begin
                if (exc_take) begin
                    pc_q         <= HANDLER_VECTOR;
                    epc_q        <= pc_q;
                    cause_q      <= ExcReq ? ExcCode : ADEL_CODE;
                    in_handler_q <= 1'b1;
                end else if (int_take) begin
                    // The current instruction completes; resume at its successor.
                    pc_q         <= HANDLER_VECTOR;
                    epc_q        <= seq_next;
                    cause_q      <= INT_CODE;
                    in_handler_q <= 1'b1;
                end else if (Eret) begin
                    pc_q         <= epc_q;
                    in_handler_q <= 1'b0;
                end else begin
                    pc_q <= seq_next;
                end
            end
        end
    end

    assign PC        = pc_q;
    assign PCPlus4   = pc_plus4;
    assign EPC       = epc_q;
    assign CauseCode = cause_q;
    assign InHandler = in_handler_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit: sequencing, branch/jump/jr,
// trap entry and return, interrupt pending behaviour, stall, wrap and reset.
module tb_fetch_pc_unit;

    logic        Clk;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [15:0] Imm16;
    logic        JumpEn;
    logic [25:0] JumpIdx;
    logic        JrEn;
    logic [31:0] RegTarget;
    logic        Eret;
    logic        ExcReq;
    logic [4:0]  ExcCode;
    logic        IntReq;
    logic        IE;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] EPC;
    logic [4:0]  CauseCode;
    logic        InHandler;

    int tests  = 0;
    int failed = 0;

    fetch_pc_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .Imm16       (Imm16),
        .JumpEn      (JumpEn),
        .JumpIdx     (JumpIdx),
        .JrEn        (JrEn),
        .RegTarget   (RegTarget),
        .Eret        (Eret),
        .ExcReq      (ExcReq),
        .ExcCode     (ExcCode),
        .IntReq      (IntReq),
        .IE          (IE),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .EPC         (EPC),
        .CauseCode   (CauseCode),
        .InHandler   (InHandler)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle before sampling.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; Imm16 = 16'h0;
        JumpEn = 1'b0; JumpIdx = 26'h0; JrEn = 1'b0; RegTarget = 32'h0;
        Eret = 1'b0; ExcReq = 1'b0; ExcCode = 5'd0; IntReq = 1'b0; IE = 1'b0;

        // Reset state
        step();
        check("rst_pc", PC, 32'h0);
        check("rst_pcplus4", PCPlus4, 32'h4);
        check("rst_epc", EPC, 32'h0);
        check("rst_cause", {27'd0, CauseCode}, 32'd0);
        check("rst_inhandler", {31'd0, InHandler}, 32'd0);
        Reset = 1'b0;

        // Sequential fetch
        step(); check("seq_pc1", PC, 32'h4);
        step(); check("seq_pc2", PC, 32'h8);
        step(); check("seq_pc3", PC, 32'hC);
        check("seq_pcplus4", PCPlus4, 32'h10);
        check("seq_inhandler", {31'd0, InHandler}, 32'd0);

        // Branches forward and backward
        BranchTaken = 1'b1; Imm16 = 16'h0001;
        step(); check("br_fwd", PC, 32'h14);
        Imm16 = 16'hFFFE;
        step(); check("br_back", PC, 32'h10);
        BranchTaken = 1'b0;

        // Jr to 0x50, then jump, then aligned and misaligned jr
        JrEn = 1'b1; RegTarget = 32'h50;
        step(); check("jr_50", PC, 32'h50);
        JrEn = 1'b0; JumpEn = 1'b1; JumpIdx = 26'h16;
        step(); check("jump", PC, 32'h58);
        JumpEn = 1'b0; JrEn = 1'b1; RegTarget = 32'h10;
        step(); check("jr_10", PC, 32'h10);
        RegTarget = 32'h12;
        step();
        check("adel_pc", PC, 32'h70);
        check("adel_epc", EPC, 32'h10);
        check("adel_cause", {27'd0, CauseCode}, 32'd4);
        check("adel_inhandler", {31'd0, InHandler}, 32'd1);
        JrEn = 1'b0;

        // Return, then walk to 0x1C
        Eret = 1'b1;
        step(); check("eret_pc", PC, 32'h10);
        check("eret_inhandler", {31'd0, InHandler}, 32'd0);
        Eret = 1'b0;
        step(); step(); step();
        check("walk_1c", PC, 32'h1C);

        // Interrupt edge captured at 0x1C becomes pending; taken at 0x20
        IntReq = 1'b1; IE = 1'b1;
        step(); check("int_pc20", PC, 32'h20);
        step();
        check("int_pc", PC, 32'h70);
        check("int_epc", EPC, 32'h24);
        check("int_cause", {27'd0, CauseCode}, 32'd0);
        check("int_inhandler", {31'd0, InHandler}, 32'd1);

        // Second edge during the handler stays pending
        IntReq = 1'b0;
        step(); check("hdl_pc74", PC, 32'h74);
        IntReq = 1'b1;
        step(); check("hdl_pc78", PC, 32'h78);
        check("hdl_inhandler", {31'd0, InHandler}, 32'd1);
        Eret = 1'b1;
        step(); check("int_eret_pc", PC, 32'h24);
        check("int_eret_inhandler", {31'd0, InHandler}, 32'd0);
        Eret = 1'b0;
        step();
        check("int2_pc", PC, 32'h70);
        check("int2_epc", EPC, 32'h28);
        check("int2_inhandler", {31'd0, InHandler}, 32'd1);

        // Masked edge under stall: PC holds, no trap
        IntReq = 1'b0; Eret = 1'b1;
        step(); check("eret2_pc", PC, 32'h28);
        Eret = 1'b0; IE = 1'b0; IntReq = 1'b1; Stall = 1'b1;
        step(); check("stall_pc1", PC, 32'h28);
        step(); check("stall_pc2", PC, 32'h28);
        step(); check("stall_pc3", PC, 32'h28);
        check("stall_inhandler", {31'd0, InHandler}, 32'd0);
        IE = 1'b1; Stall = 1'b0;
        step();
        check("unmask_pc", PC, 32'h70);
        check("unmask_epc", EPC, 32'h2C);
        check("unmask_inhandler", {31'd0, InHandler}, 32'd1);

        // ExcReq wins over a pending interrupt, which stays pending
        IntReq = 1'b0; IE = 1'b0; Eret = 1'b1;
        step(); check("eret3_pc", PC, 32'h2C);
        Eret = 1'b0;
        step(); check("pc30", PC, 32'h30);
        IntReq = 1'b1;
        step(); check("pc34", PC, 32'h34);
        IE = 1'b1; ExcReq = 1'b1; ExcCode = 5'd12;
        step();
        check("exc_pc", PC, 32'h70);
        check("exc_epc", EPC, 32'h34);
        check("exc_cause", {27'd0, CauseCode}, 32'd12);
        ExcReq = 1'b0; Eret = 1'b1;
        step(); check("eret4_pc", PC, 32'h34);
        Eret = 1'b0;
        step();
        check("late_int_pc", PC, 32'h70);
        check("late_int_epc", EPC, 32'h38);
        check("late_int_cause", {27'd0, CauseCode}, 32'd0);

        // Wrap at the top of the address space
        IntReq = 1'b0; IE = 1'b0; Eret = 1'b1;
        step(); check("eret5_pc", PC, 32'h38);
        Eret = 1'b0; JrEn = 1'b1; RegTarget = 32'hFFFF_FFFC;
        step(); check("jr_top", PC, 32'hFFFF_FFFC);
        check("top_pcplus4", PCPlus4, 32'h0);
        JrEn = 1'b0;
        step(); check("wrap_pc", PC, 32'h0);

        // Stalled exception is deferred, not dropped
        Stall = 1'b1; ExcReq = 1'b1; ExcCode = 5'd7;
        step(); check("stall_exc_pc", PC, 32'h0);
        check("stall_exc_inhandler", {31'd0, InHandler}, 32'd0);
        Stall = 1'b0;
        step();
        check("defer_exc_pc", PC, 32'h70);
        check("defer_exc_cause", {27'd0, CauseCode}, 32'd7);
        ExcReq = 1'b0;
        step(); check("hdl2_pc74", PC, 32'h74);

        // Nested exception overwrites EPC; also leave an interrupt pending
        ExcReq = 1'b1; ExcCode = 5'd5; IntReq = 1'b1; IE = 1'b1;
        step();
        check("nest_epc", EPC, 32'h74);
        check("nest_cause", {27'd0, CauseCode}, 32'd5);
        ExcReq = 1'b0;

        // Reset mid-handler clears everything, including the pending interrupt
        Reset = 1'b1;
        step();
        check("rst2_pc", PC, 32'h0);
        check("rst2_epc", EPC, 32'h0);
        check("rst2_cause", {27'd0, CauseCode}, 32'd0);
        check("rst2_inhandler", {31'd0, InHandler}, 32'd0);
        Reset = 1'b0; IntReq = 1'b0;
        step(); check("post_rst_pc1", PC, 32'h4);
        step(); check("post_rst_pc2", PC, 32'h8);
        check("post_rst_inhandler", {31'd0, InHandler}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
